// File: rtl/if_fetch_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
// The ack may arrive in the same cycle the request is raised.
interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (output mem_req_o, output mem_addr_o, input mem_ack_i, input mem_rdata_i);
  modport slave  (input mem_req_o, input mem_addr_o, output mem_ack_i, output mem_rdata_i);
endinterface

// File: rtl/if_fetch.sv
// Fetch stage: owns the PC, drives the instruction-memory handshake and feeds decode
// through a registered output slot backed by a one-entry skid buffer.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  if_fetch_if.master  mem,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_FULL    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] addr_q;
  slot_t       slot_q;
  slot_t       skid_q;
  logic        slot_vld;
  logic        skid_vld;

  logic        req;
  logic        ack;
  logic        consume;
  logic        slot_free;
  logic [31:0] next_pc;
  slot_t       resp;

  // Request is combinational from state so a zero-wait memory can ack in the issue cycle.
  assign req       = rst && (state != S_FULL);
  assign ack       = req && mem.mem_ack_i;
  assign consume   = slot_vld && !stall_i;
  assign slot_free = !slot_vld || consume;
  assign next_pc   = fetch_pc + PC_STEP;
  assign resp      = '{pc: addr_q, inst: mem.mem_rdata_i};

  assign mem.mem_req_o  = req;
  assign mem.mem_addr_o = addr_q;
  assign pc_o           = slot_q.pc;
  assign inst_o         = slot_q.inst;
  assign inst_valid_o   = slot_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      slot_q   <= '0;
      skid_q   <= '0;
      slot_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (branch_flag_i) begin
      fetch_pc <= branch_target_i;
      slot_vld <= 1'b0;
      skid_vld <= 1'b0;
      // An unacked request must complete before the target can go out.
      if (state == S_FULL || ack) begin
        addr_q <= branch_target_i;
        state  <= S_REQ;
      end else begin
        state  <= S_DISCARD;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (ack) begin
            fetch_pc <= next_pc;
            addr_q   <= next_pc;
            if (slot_free) begin
              slot_q   <= resp;
              slot_vld <= 1'b1;
            end else begin
              skid_q   <= resp;
              skid_vld <= 1'b1;
              state    <= S_FULL;
            end
          end else if (consume) begin
            slot_vld <= 1'b0;
          end
        end
        S_FULL: begin
          if (consume && skid_vld) begin
            slot_q   <= skid_q;
            slot_vld <= 1'b1;
            skid_vld <= 1'b0;
            addr_q   <= fetch_pc;
            state    <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (ack) begin
            addr_q <= fetch_pc;
            state  <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a small memory model with programmable wait states,
// rdata = addr ^ 32'hA5A5_0000, and per-scenario tasks with inline checks.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] pc, inst;
  logic        valid;
  logic        ack_force = 1'b0;
  int          wlat = 0;
  int          wcnt = 0;
  int          checks = 0;
  int          failures = 0;

  if_fetch_if mif ();

  if_fetch #(.RESET_PC(32'h100), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
    .branch_target_i(target), .mem(mif.master),
    .pc_o(pc), .inst_o(inst), .inst_valid_o(valid)
  );

  always #5 clk = ~clk;

  assign mif.mem_ack_i   = ack_force || (mif.mem_req_o && (wcnt >= wlat));
  assign mif.mem_rdata_i = mif.mem_addr_o ^ 32'hA5A5_0000;

  always @(posedge clk)
    if (!mif.mem_req_o || mif.mem_ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;

  task automatic do_reset(input int w);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; branch = 1'b0; target = '0; ack_force = 1'b0; wlat = w;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mif.mem_req_o !== 1'b0 || valid !== 1'b0 || pc !== 32'h0 || inst !== 32'h0 ||
        mif.mem_addr_o !== 32'h100) begin
      failures++;
      $display("FAIL reset: req=%b valid=%b pc=%h inst=%h addr=%h expected 0 0 0 0 00000100",
               mif.mem_req_o, valid, pc, inst, mif.mem_addr_o);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp;
    do_reset(0);
    checks++;
    if (mif.mem_req_o !== 1'b1 || mif.mem_addr_o !== 32'h100 || valid !== 1'b0) begin
      failures++;
      $display("FAIL zw_first_req: req=%b addr=%h valid=%b expected 1 00000100 0",
               mif.mem_req_o, mif.mem_addr_o, valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp = 32'h100 + 32'(4 * i);
      checks++;
      if (valid !== 1'b1 || pc !== exp || inst !== (exp ^ 32'hA5A5_0000)) begin
        failures++;
        $display("FAIL zw_seq%0d: valid=%b pc=%h inst=%h expected 1 %h %h",
                 i, valid, pc, inst, exp, exp ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mif.mem_req_o !== 1'b1 || mif.mem_addr_o !== 32'h100 || valid !== 1'b0) begin
        failures++;
        $display("FAIL wait_hold%0d: req=%b addr=%h valid=%b expected 1 00000100 0",
                 i, mif.mem_req_o, mif.mem_addr_o, valid);
      end
      @(negedge clk);
    end
    checks++;
    if (valid !== 1'b1 || pc !== 32'h100 || inst !== 32'hA5A5_0100 || mif.mem_addr_o !== 32'h104) begin
      failures++;
      $display("FAIL wait_deliver: valid=%b pc=%h inst=%h addr=%h expected 1 00000100 a5a50100 00000104",
               valid, pc, inst, mif.mem_addr_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 32'h104) begin
      failures++;
      $display("FAIL stall_pre: valid=%b pc=%h expected 1 00000104", valid, pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || pc !== 32'h104 || mif.mem_req_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h req=%b expected 1 00000104 0",
                 i, valid, pc, mif.mem_req_o);
      end
    end
    stall = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp = 32'h104 + 32'(4 * i);
      checks++;
      if (valid !== 1'b1 || pc !== exp || inst !== (exp ^ 32'hA5A5_0000)) begin
        failures++;
        $display("FAIL stall_release%0d: valid=%b pc=%h inst=%h expected 1 %h %h",
                 i, valid, pc, inst, exp, exp ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic test_branch_pending();
    do_reset(0);
    repeat (3) @(negedge clk);
    checks++;
    if (mif.mem_addr_o !== 32'h10C) begin
      failures++;
      $display("FAIL brp_setup: addr=%h expected 0000010c", mif.mem_addr_o);
    end
    wlat = 2; branch = 1'b1; target = 32'h400;
    @(negedge clk);
    branch = 1'b0;
    checks++;
    if (mif.mem_addr_o !== 32'h10C || mif.mem_req_o !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL brp_drain: addr=%h req=%b valid=%b expected 0000010c 1 0",
               mif.mem_addr_o, mif.mem_req_o, valid);
    end
    @(negedge clk);
    checks++;
    if (mif.mem_addr_o !== 32'h10C || mif.mem_ack_i !== 1'b1) begin
      failures++;
      $display("FAIL brp_ack: addr=%h ack=%b expected 0000010c 1", mif.mem_addr_o, mif.mem_ack_i);
    end
    @(negedge clk);
    checks++;
    if (mif.mem_addr_o !== 32'h400 || valid !== 1'b0) begin
      failures++;
      $display("FAIL brp_target_req: addr=%h valid=%b expected 00000400 0", mif.mem_addr_o, valid);
    end
    wlat = 0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 32'h400 || inst !== 32'hA5A5_0400) begin
      failures++;
      $display("FAIL brp_first: valid=%b pc=%h inst=%h expected 1 00000400 a5a50400", valid, pc, inst);
    end
  endtask

  task automatic test_branch_full();
    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    checks++;
    if (mif.mem_req_o !== 1'b0 || pc !== 32'h104) begin
      failures++;
      $display("FAIL brf_full: req=%b pc=%h expected 0 00000104", mif.mem_req_o, pc);
    end
    branch = 1'b1; target = 32'h800;
    @(negedge clk);
    branch = 1'b0;
    checks++;
    if (valid !== 1'b0 || mif.mem_addr_o !== 32'h800 || mif.mem_req_o !== 1'b1) begin
      failures++;
      $display("FAIL brf_flush: valid=%b addr=%h req=%b expected 0 00000800 1",
               valid, mif.mem_addr_o, mif.mem_req_o);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 32'h800) begin
      failures++;
      $display("FAIL brf_first: valid=%b pc=%h expected 1 00000800", valid, pc);
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 32'h804) begin
      failures++;
      $display("FAIL brf_second: valid=%b pc=%h expected 1 00000804", valid, pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(5);
    @(negedge clk);
    rst = 1'b0; ack_force = 1'b1;
    @(negedge clk);
    checks++;
    if (mif.mem_req_o !== 1'b0 || valid !== 1'b0 || mif.mem_addr_o !== 32'h100) begin
      failures++;
      $display("FAIL rmid_held: req=%b valid=%b addr=%h expected 0 0 00000100",
               mif.mem_req_o, valid, mif.mem_addr_o);
    end
    rst = 1'b1; ack_force = 1'b0; wlat = 0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 32'h100 || inst !== 32'hA5A5_0100 || mif.mem_addr_o !== 32'h104) begin
      failures++;
      $display("FAIL rmid_restart: valid=%b pc=%h inst=%h addr=%h expected 1 00000100 a5a50100 00000104",
               valid, pc, inst, mif.mem_addr_o);
    end
  endtask

  task automatic test_wrap();
    do_reset(0);
    @(negedge clk);
    branch = 1'b1; target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch = 1'b0;
    checks++;
    if (mif.mem_addr_o !== 32'hFFFF_FFFC || valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_req: addr=%h valid=%b expected fffffffc 0", mif.mem_addr_o, valid);
    end
    @(negedge clk);
    checks++;
    if (pc !== 32'hFFFF_FFFC || inst !== 32'h5A5A_FFFC || mif.mem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL wrap_top: pc=%h inst=%h addr=%h expected fffffffc 5a5afffc 00000000",
               pc, inst, mif.mem_addr_o);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || pc !== 32'h0 || inst !== 32'hA5A5_0000) begin
      failures++;
      $display("FAIL wrap_zero: valid=%b pc=%h inst=%h expected 1 00000000 a5a50000", valid, pc, inst);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch_pending();
    test_branch_full();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
